// File: rtl/irq_controller.sv
// irq_controller: edge-captured, maskable interrupt controller with lowest-index priority.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on every irq_src bit.
module irq_controller #(
    parameter int         NUM_SRC   = 8,
    parameter logic [4:0] BASE_ADDR = 5'b11000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [31:0]        dataIn,
    output logic [31:0]        dataOut,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq,
    output logic [4:0]         irq_id
);
    // Registers are kept 32 bits wide; bits at and above NUM_SRC are forced to 0.
    localparam logic [31:0] VALID  = 32'((64'd1 << NUM_SRC) - 64'd1);
    localparam logic [4:0]  A_PEND = BASE_ADDR;
    localparam logic [4:0]  A_MASK = BASE_ADDR + 5'd1;
    localparam logic [4:0]  A_CAUS = BASE_ADDR + 5'd2;
    localparam logic [4:0]  A_ACK  = BASE_ADDR + 5'd3;

    logic [31:0] src, src_q, pending, mask, eff, rise, clr, pending_n;
    logic [4:0]  id_n;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end
    assign src = 32'(sync2);
`else
    assign src = 32'(irq_src);
`endif

    // An ACK index >= NUM_SRC shifts to a bit that VALID strips.
    assign rise      = src & ~src_q;
    assign clr       = ({32{we && addr == A_PEND}} & dataIn)
                     | ({32{we && addr == A_ACK}} & (32'd1 << dataIn[4:0]));
    assign pending_n = ((pending & ~clr) | rise) & VALID;
    assign eff       = pending & mask;

    always_comb begin
        id_n = '0;
        for (int i = 31; i >= 0; i--)
            if (eff[i]) id_n = 5'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
            irq     <= 1'b0;
            irq_id  <= '0;
        end else begin
            src_q   <= src;
            pending <= pending_n;
            if (we && addr == A_MASK) mask <= dataIn & VALID;
            irq     <= |eff;
            irq_id  <= id_n;
        end
    end

    assign dataOut = addr == A_PEND ? pending :
                     addr == A_MASK ? mask :
                     addr == A_CAUS ? {irq, 26'd0, irq_id} : 32'd0;
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller that sits directly downstream of the timer peripheral and other flag-producing peripherals.
- Captures rising edges on peripheral flag lines into a pending register.
- Applies a software mask and presents one registered interrupt request plus the highest-priority cause ID to the CPU.
- Uses the same we/addr/dataIn bus as the timer; the timer's flag connects to irq_src[0].

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32); bit 0 is the timer flag.
- BASE_ADDR, 5'b11000, 5-bit base address; registers occupy BASE_ADDR..BASE_ADDR+3 (must not overlap timer addresses 5'b10110/5'b10111).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately.
- we  in  1  bus write enable.
- addr  in  5  bus register address.
- dataIn  in  32  bus write data.
- dataOut  out  32  bus read data; combinational from addr; 0 for unmapped addresses.
- irq_src  in  NUM_SRC  peripheral flag inputs; irq_src[0] is the timer flag.
- irq  out  1  registered interrupt request to the CPU.
- irq_id  out  5  registered ID of the highest-priority pending, unmasked source.

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 PENDING: read returns pending bits; write is write-1-to-clear.
  - +1 MASK: read/write; bit=1 enables the source.
  - +2 CAUSE: read-only; bit31=irq, bits4:0=irq_id.
  - +3 ACK: write-only; clears pending[dataIn[4:0]]; reads return 0.
- Bits at and above NUM_SRC read 0 and ignore writes. Writes to unmapped addresses are ignored.
- Reset (rst=0, asynchronous): pending=0, mask=0, src_q=0, irq=0, irq_id=0, dataOut reflects the cleared registers.
- Edge detect: src_q <= irq_src each cycle. rise = irq_src & ~src_q. pending |= rise.
  - A source held high sets pending once only; it must fall and rise again to re-set.
  - Level at reset release: src_q=0 after reset, so a source already high is taken as one rising edge on the first clock.
- Pending latches regardless of mask. Masking hides a source from irq but does not clear its pending bit. Unmasking an already-pending source raises irq on the next cycle.
- Simultaneous set and clear (rise and W1C/ACK on the same bit, same cycle): set wins; the bit stays 1.
- Priority: lowest index wins. eff = pending & mask.
  - irq <= |eff.
  - irq_id <= index of lowest set bit of eff, or 0 if eff=0.
- Latency:
  - Source rises before edge E0 → pending set at E0 → irq/irq_id valid after E1 (2-cycle latency).
  - Clear at edge Ec → irq deasserts after Ec+1 if no other source is pending.
- ACK with an ID >= NUM_SRC has no effect.
- Reset asserted mid-operation, including during a write: all state clears immediately; the write is lost.
- dataOut is independent of we; a read of PENDING in the same cycle as a W1C returns the pre-write value.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - Each irq_src bit passes through a 2-flop synchronizer (reset to 0) before edge detection.
  - Source-to-irq latency becomes 4 cycles.
  - Suitable for sources in other clock domains.
- Undefined:
  - No synchronizer; 2-cycle latency as above.
  - All sources must be synchronous to clk.

Test Plan:
- Reset: drive rst=0 with irq_src=8'hFF, then release → pending=0, irq=0 during reset; first clock after release sets pending=8'hFF; with mask=0, irq stays 0.
- Single timer edge: mask=8'h01; pulse irq_src[0] for one cycle before edge E0 → irq=1 and irq_id=0 after E1; CAUSE reads 32'h8000_0000; write ACK with dataIn=0 → irq=0 two edges later.
- Priority: mask=8'hFF; raise irq_src[5] and irq_src[2] together → irq_id=2; ACK id 2 → irq_id=5 and irq stays 1; ACK id 5 → irq=0.
- Set/clear race: with pending[3]=1, write PENDING=8'h08 in the same cycle a new rising edge arrives on irq_src[3] → pending[3] remains 1.
- Mask gating: irq_src[4] edge with mask=0 → pending=8'h10, irq=0; write MASK=8'h10 → irq=1, irq_id=4 one cycle later; held-high source does not re-set pending after W1C.
- Bus isolation: write to 5'b10110 and 5'b11111 → no register changes; read of an unmapped address returns 0; with IRQ_SYNC_EN defined, the single timer edge scenario shows irq one cycle after pending, 4 cycles after the source edge.
